// File: rtl/adf_loader.sv
// adf_loader: register bank with dirty tracking plus a serial shifter that loads
// changed words into an ADF synthesizer, highest register index first.
module adf_loader #(
    parameter int unsigned CLK_DIV = 16,
    parameter int unsigned NREG    = 4,
    parameter int unsigned WORD_W  = 24
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      wr_en,
    input  logic [((NREG > 1) ? $clog2(NREG) : 1)-1:0] wr_addr,
    input  logic [WORD_W-1:0]                         wr_data,
    input  logic                                      force_all,
    output logic                                      adf_clk,
    output logic                                      adf_data,
    output logic                                      adf_le,
    output logic                                      busy,
    output logic                                      done,
    output logic [NREG-1:0]                           pending
);

    localparam int unsigned AW    = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BC_W  = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [BC_W-1:0]  BITS_LAST = BC_W'(WORD_W);

    typedef enum logic [2:0] {
        IDLE, SHIFT_LO, SHIFT_HI, LE_SETUP, LE_HIGH, GAP
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [BC_W-1:0]     bits, bits_n;
    logic [WORD_W-1:0]   shreg, shreg_n;
    logic [WORD_W-1:0]   bank [NREG];
    logic [NREG-1:0]     dirty, dirty_n;
    logic                clk_n, data_n, le_n, done_n;
    logic                cap, phase_end, wr_ok;
    logic [AW-1:0]       cap_idx;

    assign pending = dirty;
    assign wr_ok   = wr_en && (32'(wr_addr) < NREG);

    // Next-state, next-output and dirty-bit logic
    always_comb begin
        state_n   = state;
        cnt_n     = '0;
        bits_n    = bits;
        shreg_n   = shreg;
        clk_n     = adf_clk;
        data_n    = adf_data;
        le_n      = adf_le;
        done_n    = 1'b0;
        cap       = 1'b0;
        cap_idx   = '0;
        phase_end = (cnt == CNT_LAST);

        for (int i = 0; i < NREG; i++) begin
            if (dirty[i]) cap_idx = AW'(i);
        end

        if (state != IDLE && !phase_end) cnt_n = cnt + CNT_W'(1);

        case (state)
            IDLE: begin
                if (|dirty) begin
                    cap     = 1'b1;
                    shreg_n = bank[cap_idx];
                    data_n  = bank[cap_idx][WORD_W-1];
                    clk_n   = 1'b0;
                    bits_n  = '0;
                    state_n = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    clk_n   = 1'b1;
                    state_n = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    clk_n  = 1'b0;
                    bits_n = bits + BC_W'(1);
                    if (bits_n == BITS_LAST) begin
                        data_n  = 1'b0;
                        state_n = LE_SETUP;
                    end else begin
                        shreg_n = {shreg[WORD_W-2:0], 1'b0};
                        data_n  = shreg[WORD_W-2];
                        state_n = SHIFT_LO;
                    end
                end
            end
            LE_SETUP: begin
                if (phase_end) begin
                    le_n    = 1'b1;
                    state_n = LE_HIGH;
                end
            end
            LE_HIGH: begin
                if (phase_end) begin
                    le_n    = 1'b0;
                    state_n = GAP;
                end
            end
            GAP: begin
                if (phase_end) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // A write's set wins over the capture's clear on the same edge
        dirty_n = dirty;
        if (cap) dirty_n[cap_idx] = 1'b0;
        if (force_all) dirty_n = '1;
        if (wr_ok) dirty_n[wr_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bits     <= '0;
            shreg    <= '0;
            dirty    <= '0;
            adf_clk  <= 1'b0;
            adf_data <= 1'b0;
            adf_le   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < NREG; i++) bank[i] <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bits     <= bits_n;
            shreg    <= shreg_n;
            dirty    <= dirty_n;
            adf_clk  <= clk_n;
            adf_data <= data_n;
            adf_le   <= le_n;
            busy     <= (state_n != IDLE);
            done     <= done_n;
            if (wr_ok) bank[wr_addr] <= wr_data;
        end
    end

endmodule
